pc_redirect_ctrl: RTL

Sequencing controller for the IF-stage PC register. Each cycle it decides whether the PC advances, holds, or loads a redirect target, choosing among trap, EX-stage branch-resolution and ID-stage jump requests. It honours the instruction-memory handshake and the hazard-unit stall, and emits the IF/ID and ID/EX flush strobes. It sits between the hazard unit, the EX/ID redirect sources and the PC register.

---
 rtl/pc_ctrl_pkg.sv | 30 +++
 rtl/redirect_prio_sel.sv | 51 +++++
 rtl/pc_redirect_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg
// Shared types for the IF-stage PC redirect controller:
//   pc_state_t     - controller state encoding (BOOT/RUN/HOLD)
//   redirect_src_t - redirect source; numeric order equals priority
//   DEF_*_VECTOR   - default reset and trap vectors
//   sat_inc32      - saturating increment used by the optional counters
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_t;

    // Higher value wins, so "new >= pending" is a plain numeric compare.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ID   = 2'd1,
        SRC_EX   = 2'd2,
        SRC_TRAP = 2'd3
    } redirect_src_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// redirect_prio_sel
// Combinational priority pick among redirect requests (trap > EX > ID) and
// word-alignment of the chosen target.
// Ports:
//   trap_valid, ex_valid, id_valid - qualified requests
//   ex_target, id_target           - raw targets
//   sel_valid, sel_src             - winning request and its source
//   sel_target                     - winning target with bits [1:0] cleared
//   sel_misalign                   - raw winning target had nonzero low bits
module redirect_prio_sel
    import pc_ctrl_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR)
) (
    input  logic            trap_valid,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_target,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_target,
    output logic            sel_valid,
    output redirect_src_t   sel_src,
    output logic [XLEN-1:0] sel_target,
    output logic            sel_misalign
);

    logic [XLEN-1:0] raw_target;

    always_comb begin
        sel_valid  = 1'b0;
        sel_src    = SRC_NONE;
        raw_target = '0;
        if (trap_valid) begin
            sel_valid  = 1'b1;
            sel_src    = SRC_TRAP;
            raw_target = TRAP_VECTOR;
        end else if (ex_valid) begin
            sel_valid  = 1'b1;
            sel_src    = SRC_EX;
            raw_target = ex_target;
        end else if (id_valid) begin
            sel_valid  = 1'b1;
            sel_src    = SRC_ID;
            raw_target = id_target;
        end
    end

    assign sel_target   = {raw_target[XLEN-1:2], 2'b00};
    assign sel_misalign = sel_valid && (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Decides each cycle whether the IF-stage PC advances, holds or loads a
// redirect target, and emits the IF/ID and ID/EX flush strobes.
// Optional build macro: PC_REDIRECT_PERF_EN adds saturating performance
// counters (redirect_cnt, stall_cnt, hold_cnt).
// Ports:
//   clk, rst (async, active-low)
//   imem_ready, stall_req                  - fetch handshake / hazard stall
//   trap_valid, ex_redirect_valid/ex_target, id_jump_valid/id_target
//   pc_write, pc_load, next_pc             - PC register control
//   flush_if_id, flush_id_ex, misalign_err - strobes
//
// state | meaning
// BOOT  | load RESET_VECTOR once imem accepts the fetch
// RUN   | normal fetch; redirects taken immediately when imem is ready
// HOLD  | redirect pending, waiting for imem_ready to load it
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_ready,
    input  logic            stall_req,
    input  logic            trap_valid,
    input  logic            ex_redirect_valid,
    input  logic [XLEN-1:0] ex_target,
    input  logic            id_jump_valid,
    input  logic [XLEN-1:0] id_target,
    output logic            pc_write,
    output logic            pc_load,
    output logic [XLEN-1:0] next_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            misalign_err
`ifdef PC_REDIRECT_PERF_EN
    ,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     hold_cnt
`endif
);

    pc_state_t       state, state_nx;
    logic [XLEN-1:0] pend_target, pend_target_nx;
    redirect_src_t   pend_src, pend_src_nx;

    logic            sel_valid;
    redirect_src_t   sel_src;
    logic [XLEN-1:0] sel_target;
    logic            sel_misalign;
    logic            accept;

    // The jump sits in a stalled ID slot, and in HOLD anything in ID is
    // wrong-path, so ID only competes in RUN without a stall.
    redirect_prio_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_sel (
        .trap_valid   (trap_valid && state != BOOT),
        .ex_valid     (ex_redirect_valid && state != BOOT),
        .ex_target    (ex_target),
        .id_valid     (id_jump_valid && !stall_req && state == RUN),
        .id_target    (id_target),
        .sel_valid    (sel_valid),
        .sel_src      (sel_src),
        .sel_target   (sel_target),
        .sel_misalign (sel_misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            pend_target <= '0;
            pend_src    <= SRC_NONE;
        end else begin
            state       <= state_nx;
            pend_target <= pend_target_nx;
            pend_src    <= pend_src_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        pend_target_nx = pend_target;
        pend_src_nx    = pend_src;
        pc_write       = 1'b0;
        pc_load        = 1'b0;
        next_pc        = pend_target;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        misalign_err   = 1'b0;
        accept         = 1'b0;

        case (state)
            BOOT: begin
                pc_load     = 1'b1;
                next_pc     = RESET_VECTOR;
                flush_if_id = 1'b1;
                if (imem_ready) begin
                    pc_write = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (sel_valid) begin
                    accept       = 1'b1;
                    next_pc      = sel_target;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = (sel_src != SRC_ID);
                    misalign_err = sel_misalign;
                    if (imem_ready) begin
                        pc_write = 1'b1;
                        pc_load  = 1'b1;
                    end else begin
                        pend_target_nx = sel_target;
                        pend_src_nx    = sel_src;
                        state_nx       = HOLD;
                    end
                end else begin
                    pc_write = imem_ready && !stall_req;
                end
            end
            HOLD: begin
                flush_if_id = 1'b1;
                // Equal priority also overwrites: the newest trap/EX wins.
                if (sel_valid && sel_src >= pend_src) begin
                    accept         = 1'b1;
                    pend_target_nx = sel_target;
                    pend_src_nx    = sel_src;
                    flush_id_ex    = 1'b1;
                    misalign_err   = sel_misalign;
                    next_pc        = sel_target;
                end
                if (imem_ready) begin
                    pc_write    = 1'b1;
                    pc_load     = 1'b1;
                    pend_src_nx = SRC_NONE;
                    state_nx    = RUN;
                end
            end
            default: state_nx = BOOT;
        endcase

        // Outputs read as reset values for as long as rst is held low.
        if (!rst) begin
            pc_write     = 1'b0;
            pc_load      = 1'b0;
            next_pc      = RESET_VECTOR;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
            misalign_err = 1'b0;
            accept       = 1'b0;
        end
    end

`ifdef PC_REDIRECT_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
            hold_cnt     <= '0;
        end else begin
            if (accept)
                redirect_cnt <= sat_inc32(redirect_cnt);
            if (state == RUN && !pc_write)
                stall_cnt <= sat_inc32(stall_cnt);
            if (state == HOLD)
                hold_cnt <= sat_inc32(hold_cnt);
        end
    end
`endif

endmodule
